// File: rtl/decoder_2x4_hold_if.sv
// Receive-side link between the 4x2 encoder and the 2-to-4 hold decoder.
// The source drives the code and valid; the decoder returns ready and the held one-hot.
interface decoder_2x4_hold_if;
  logic in_valid;
  logic in_ready;
  logic a;
  logic b;
  logic d1;
  logic d2;
  logic d3;
  logic d4;
  logic out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    input  in_ready,
    input  d1,
    input  d2,
    input  d3,
    input  d4,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output in_ready,
    output d1,
    output d2,
    output d3,
    output d4,
    output out_valid
  );
endinterface

// File: rtl/decoder_2x4_hold.sv
// Registered 2-to-4 decoder: each accepted {a,b} code is held one-hot on d1..d4
// for exactly HOLD_CYCLES clocks, back-to-back codes switch with no zero gap.
//
// state | meaning
// IDLE  | no code held, all outputs low, ready for a code
// HOLD  | one d line high; cnt counts down the remaining hold clocks
module decoder_2x4_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input logic            clk,
  input logic            rst,
  decoder_2x4_hold_if.slave bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    d_q;
  logic          out_valid_q;
  logic          xfer;

  function automatic logic [3:0] decode(input logic [1:0] code);
    logic [3:0] onehot;
    case (code)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      default: onehot = 4'b1000;
    endcase
    return onehot;
  endfunction

  // A new code may land on the last hold clock, so the outputs never dip to zero.
  assign bus.in_ready = ~rst & ((state == IDLE) | (cnt == '0));
  assign xfer         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            d_q         <= decode({bus.a, bus.b});
            cnt         <= CNT_LOAD;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (xfer) begin
            d_q         <= decode({bus.a, bus.b});
            cnt         <= CNT_LOAD;
            out_valid_q <= 1'b1;
          end else begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          d_q         <= '0;
          cnt         <= '0;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.d1        = d_q[0];
  assign bus.d2        = d_q[1];
  assign bus.d3        = d_q[2];
  assign bus.d4        = d_q[3];
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_decoder_2x4_hold.sv
// Bench for decoder_2x4_hold: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance share clk/rst.
// Each accept pushes its per-cycle expected one-hot values; a negedge monitor pops and compares.
module tb_decoder_2x4_hold;

  localparam int H4 = 4;
  localparam int H1 = 1;

  logic clk;
  logic rst;
  bit   mon_en;
  int   checks;
  int   failures;

  logic [3:0] sb4[$];
  logic [3:0] sb1[$];

  decoder_2x4_hold_if bus4 ();
  decoder_2x4_hold_if bus1 ();

  decoder_2x4_hold #(.HOLD_CYCLES(H4), .CW(8)) u_dec4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  decoder_2x4_hold #(.HOLD_CYCLES(H1), .CW(8)) u_dec1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Push the expected per-cycle outputs of every accepted code; an accept happens
  // exactly when the bench's queue for that instance has drained.
  task automatic push_loop();
    logic [3:0] oh;
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (bus4.in_valid === 1'b1 && sb4.size() == 0) begin
          oh = 4'b0001 << {bus4.a, bus4.b};
          for (int i = 0; i < H4; i++) sb4.push_back(oh);
        end
        if (bus1.in_valid === 1'b1 && sb1.size() == 0) begin
          oh = 4'b0001 << {bus1.a, bus1.b};
          for (int i = 0; i < H1; i++) sb1.push_back(oh);
        end
      end
    end
  endtask

  task automatic monitor_loop();
    logic [3:0] e4;
    logic [3:0] e1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        e4 = (sb4.size() != 0) ? sb4.pop_front() : 4'b0000;
        e1 = (sb1.size() != 0) ? sb1.pop_front() : 4'b0000;
        checks++;
        if ({bus4.d4, bus4.d3, bus4.d2, bus4.d1} !== e4) begin
          failures++;
          $display("FAIL dec4_onehot t=%0t got=%b exp=%b", $time,
                   {bus4.d4, bus4.d3, bus4.d2, bus4.d1}, e4);
        end
        checks++;
        if (bus4.out_valid !== (|e4)) begin
          failures++;
          $display("FAIL dec4_out_valid t=%0t got=%b exp=%b", $time, bus4.out_valid, |e4);
        end
        checks++;
        if (bus4.in_ready !== (sb4.size() == 0)) begin
          failures++;
          $display("FAIL dec4_in_ready t=%0t got=%b exp=%b", $time, bus4.in_ready, sb4.size() == 0);
        end
        checks++;
        if ({bus1.d4, bus1.d3, bus1.d2, bus1.d1} !== e1) begin
          failures++;
          $display("FAIL dec1_onehot t=%0t got=%b exp=%b", $time,
                   {bus1.d4, bus1.d3, bus1.d2, bus1.d1}, e1);
        end
        checks++;
        if (bus1.out_valid !== (|e1)) begin
          failures++;
          $display("FAIL dec1_out_valid t=%0t got=%b exp=%b", $time, bus1.out_valid, |e1);
        end
        checks++;
        if (bus1.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL dec1_in_ready t=%0t got=%b exp=1", $time, bus1.in_ready);
        end
      end
    end
  endtask

  // Present a code and keep it until the accepting edge; optionally drop valid after it.
  task automatic send(input bit sel1, input logic [1:0] code, input bit drop);
    int guard;
    @(negedge clk);
    #1;
    if (sel1) begin
      bus1.in_valid = 1'b1;
      {bus1.a, bus1.b} = code;
    end else begin
      bus4.in_valid = 1'b1;
      {bus4.a, bus4.b} = code;
    end
    guard = 0;
    while (((sel1 ? sb1.size() : sb4.size()) != 0) && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout code=%b got=busy exp=ready", code);
    end
    @(posedge clk);
    #1;
    if (drop) begin
      if (sel1) bus1.in_valid = 1'b0;
      else bus4.in_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = 1'b0; bus4.b = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
    #3;
    checks++;
    if ({bus4.d4, bus4.d3, bus4.d2, bus4.d1, bus4.out_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_dec4_outputs got=%b exp=00000",
               {bus4.d4, bus4.d3, bus4.d2, bus4.d1, bus4.out_valid});
    end
    checks++;
    if ({bus1.d4, bus1.d3, bus1.d2, bus1.d1, bus1.out_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_dec1_outputs got=%b exp=00000",
               {bus1.d4, bus1.d3, bus1.d2, bus1.d1, bus1.out_valid});
    end
    checks++;
    if ({bus4.in_ready, bus1.in_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=00", {bus4.in_ready, bus1.in_ready});
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus4.in_ready, bus1.in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL release_in_ready got=%b exp=11", {bus4.in_ready, bus1.in_ready});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    send(1'b0, 2'b10, 1'b1);
    idle_cycles(6);
  endtask

  task automatic test_sweep();
    send(1'b0, 2'b00, 1'b0);
    send(1'b0, 2'b01, 1'b0);
    send(1'b0, 2'b10, 1'b0);
    send(1'b0, 2'b11, 1'b1);
    idle_cycles(6);
  endtask

  task automatic test_backpressure();
    send(1'b0, 2'b11, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      {bus4.a, bus4.b} = (j == 1) ? 2'b10 : 2'b01;
    end
    send(1'b0, 2'b00, 1'b1);
    idle_cycles(6);
  endtask

  task automatic test_back_to_back();
    send(1'b0, 2'b11, 1'b0);
    send(1'b0, 2'b11, 1'b1);
    idle_cycles(10);
  endtask

  task automatic test_hold1_stream();
    send(1'b1, 2'b00, 1'b0);
    send(1'b1, 2'b11, 1'b0);
    send(1'b1, 2'b01, 1'b0);
    send(1'b1, 2'b10, 1'b1);
    idle_cycles(4);
  endtask

  task automatic test_reset_mid_hold();
    send(1'b0, 2'b10, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (bus4.d3 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_d3 got=%b exp=1", bus4.d3);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus4.d4, bus4.d3, bus4.d2, bus4.d1, bus4.out_valid} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b exp=00000",
               {bus4.d4, bus4.d3, bus4.d2, bus4.d1, bus4.out_valid});
    end
    checks++;
    if (bus4.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_in_ready got=%b exp=0", bus4.in_ready);
    end
    sb4.delete();
    sb1.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready got=%b exp=1", bus4.in_ready);
    end
    mon_en = 1'b1;
    send(1'b0, 2'b01, 1'b1);
    idle_cycles(6);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mon_en   = 1'b0;
    fork
      push_loop();
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_hold1_stream();
    test_reset_mid_hold();
    checks++;
    if (sb4.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", sb4.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_2x4_hold.md
Name: decoder_2x4_hold

Overview:
- Registered 2-to-4 decoder with a valid/ready input handshake.
- Takes the 2-bit code {a,b} produced by the team's 4x2 encoder and drives the matching one-hot line d1..d4.
- Each accepted code is held on the outputs for exactly HOLD_CYCLES clocks, so slow downstream logic (LED/strobe drivers, select lines) sees a stable one-hot pulse.
- Sits at the receive end of the encoder link.

Parameters:
- HOLD_CYCLES, 4, clocks each decoded one-hot output stays asserted; legal range 1..255.
- CW, 8, hold-counter width; must satisfy 2^CW > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  code on a,b is valid this cycle
- in_ready  output  1  block accepts a code this cycle
- a  input  1  code MSB (matches encoder output a)
- b  input  1  code LSB (matches encoder output b)
- d1  output  1  asserted for code a=0,b=0
- d2  output  1  asserted for code a=0,b=1
- d3  output  1  asserted for code a=1,b=0
- d4  output  1  asserted for code a=1,b=1
- out_valid  output  1  high whenever any d output is asserted

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, d1..d4=0, out_valid=0. in_ready is forced 0 while rst=1. Release is synchronous to the next rising clk edge; the first accept is possible on the first edge with rst=0.
- Handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1. a,b are sampled only on that edge. in_valid with in_ready=0 is ignored; the source must hold the code.
- FSM states:
  - IDLE: in_ready=1, all d=0, out_valid=0.
  - HOLD: exactly one d=1, out_valid=1.
- in_ready is combinational: 1 in IDLE, or in HOLD with cnt==0. Otherwise 0.
- IDLE + transfer: register the one-hot decode of {a,b}, set cnt=HOLD_CYCLES-1, go to HOLD.
- HOLD, cnt>0: decrement cnt. Outputs unchanged; a,b ignored.
- HOLD, cnt==0, transfer: load the new one-hot, set cnt=HOLD_CYCLES-1, stay in HOLD. The outputs switch directly from the old one-hot to the new one with no zero gap, including the same code repeated.
- HOLD, cnt==0, no transfer: go to IDLE and clear all d and out_valid on that edge.
- Latency: a code accepted at edge N appears on d* after edge N and stays asserted through edge N+HOLD_CYCLES. That is exactly HOLD_CYCLES cycles high.
- One-hot invariant: at most one of d1..d4 is ever 1; out_valid equals OR(d1..d4). No X on outputs after reset.
- HOLD_CYCLES=1: cnt is always 0 in HOLD, so in_ready is constantly 1. The block becomes a 1-cycle registered decoder with full throughput.
- Reset mid-HOLD: outputs clear immediately (asynchronously) and state returns to IDLE. The held code is discarded.
- Outputs are driven only from registers; no combinational path from a,b to d*.

Test Plan:
- Reset: assert rst mid-cycle with d3=1 held -> d1..d4=0, out_valid=0, in_ready=0 immediately. After release, in_ready=1.
- Single decode, HOLD_CYCLES=4: one transfer of a=1,b=0 -> d3=1, out_valid=1 for exactly 4 cycles, then all 0. in_ready=0 for the first 3 of those cycles.
- Full code sweep: send 00,01,10,11 with in_valid held continuously -> d1,d2,d3,d4 each high for 4 cycles, back-to-back with no gap. One-hot is checked every cycle.
- Backpressure: drive in_valid=1 with a=0,b=1 during cycles where in_ready=0, changing a,b each cycle -> those values are ignored. Only the value present on the in_ready=1 edge is decoded.
- Repeated code: send 11 twice back-to-back -> d4 stays high for 8 consecutive cycles, then drops.
- HOLD_CYCLES=1 build: stream 00,11,01,10 on consecutive edges -> d1,d4,d2,d3 each high for one cycle, one cycle after each accept. in_ready stays 1 throughout.
